// File: rtl/binary_to_trit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : binary_to_trit_serializer
// Description : Converts an unsigned binary word into N_TRITS ternary digits
//               and streams them out LSB-first, one per handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module binary_to_trit_serializer #(
   parameter int BIN_W   = 8,
   parameter int N_TRITS = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BIN_W-1:0] in_data,
   output logic             trit_valid,
   input  logic             trit_ready,
   output logic [1:0]       trit,
   output logic             trit_last,
   output logic             busy
);

   function automatic longint unsigned f_pow3(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 3;
      return p;
   endfunction

   localparam longint unsigned c_pow3   = f_pow3(N_TRITS);
   localparam longint unsigned c_max_in = (64'd1 << BIN_W) - 64'd1;
   localparam int              c_cnt_w  = (N_TRITS > 1) ? $clog2(N_TRITS) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N_TRITS - 1);
   localparam int              c_st_w   = 1;

   generate
      if (c_pow3 <= c_max_in) begin : g_range_err
         $error("N_TRITS too small: 3**N_TRITS must exceed 2**BIN_W-1");
      end
      if (BIN_W < 2) begin : g_width_err
         $error("BIN_W must be at least 2");
      end
   endgenerate

   typedef enum logic [c_st_w-1:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   state_t             r_state;
   logic [BIN_W-1:0]   r_value;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_trit_valid;
   logic               r_busy;
   logic               w_last;

   // Since the input is below 3**N_TRITS, the residual value reaches zero on
   // the final trit, so trit decodes to 00 whenever the block is idle.
   assign w_last     = (r_state == S_EMIT) && (r_cnt == c_last);
   assign in_ready   = (r_state == S_IDLE);
   assign trit       = 2'(r_value % BIN_W'(3));
   assign trit_last  = w_last;
   assign trit_valid = r_trit_valid;
   assign busy       = r_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_value      <= '0;
         r_cnt        <= '0;
         r_trit_valid <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_value      <= in_data;
                  r_cnt        <= '0;
                  r_state      <= S_EMIT;
                  r_trit_valid <= 1'b1;
                  r_busy       <= 1'b1;
               end
            end
            S_EMIT: begin
               if (trit_ready) begin
                  r_value <= r_value / BIN_W'(3);
                  if (w_last) begin
                     r_cnt        <= '0;
                     r_state      <= S_IDLE;
                     r_trit_valid <= 1'b0;
                     r_busy       <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + c_cnt_w'(1);
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_trit_valid <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_binary_to_trit_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_binary_to_trit_serializer
// Description : Directed plus randomised scoreboard bench for the serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_binary_to_trit_serializer;

   localparam int BIN_W   = 8;
   localparam int N_TRITS = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [BIN_W-1:0] in_data;
   logic             trit_valid;
   logic             trit_ready;
   logic [1:0]       trit;
   logic             trit_last;
   logic             busy;

   binary_to_trit_serializer #(.BIN_W(BIN_W), .N_TRITS(N_TRITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .trit_valid (trit_valid),
      .trit_ready (trit_ready),
      .trit       (trit),
      .trit_last  (trit_last),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       last;
      logic [1:0] t;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for in_ready, offers one word and queues its expected trits.
   task automatic send(input logic [BIN_W-1:0] d);
      int v;
      int waited;
      waited = 0;
      while (in_ready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk("accept_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = d;
      v = int'(d);
      for (int i = 0; i < N_TRITS; i++) begin
         q.push_back({(i == N_TRITS - 1), 2'(v % 3)});
         v = v / 3;
      end
      tick();
      in_valid = 1'b0;
      chk("first_trit_valid", {31'd0, trit_valid}, 32'd1);
      chk("busy_emit", {31'd0, busy}, 32'd1);
      chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
   endtask

   // Consumes n trits; stall_len cycles of back-pressure before trit stall_at,
   // or random back-pressure when rnd is set.
   task automatic drain(input int n, input int stall_at, input int stall_len,
                        input bit rnd, input int word);
      int   got, stalled, budget, acc, pw;
      bit   rdy;
      exp_t e;
      got = 0; stalled = 0; budget = 0; acc = 0; pw = 1;
      while (got < n && budget < 300) begin
         if (rnd) rdy = 1'($urandom_range(0, 1));
         else     rdy = !(got == stall_at && stalled < stall_len);
         chk("valid_in_emit", {31'd0, trit_valid}, 32'd1);
         if (!rdy && !rnd && q.size() > 0) begin
            stalled++;
            chk("stall_trit_held", {30'd0, trit}, {30'd0, q[0].t});
            chk("stall_last_held", {31'd0, trit_last}, {31'd0, q[0].last});
         end
         trit_ready = rdy;
         if (trit_valid && rdy) begin
            if (q.size() == 0) begin
               chk("scoreboard_empty", q.size(), 32'd1);
            end else begin
               e = q.pop_front();
               chk("trit", {30'd0, trit}, {30'd0, e.t});
               chk("trit_last", {31'd0, trit_last}, {31'd0, e.last});
               chk("no_code_11", {31'd0, (trit == 2'b11)}, 32'd0);
               acc = acc + int'(trit) * pw;
               pw  = pw * 3;
            end
            got++;
         end
         tick();
         budget++;
      end
      trit_ready = 1'b0;
      chk("drain_count", got, n);
      if (n == N_TRITS) begin
         chk("reassembled", acc, word);
         chk("in_ready_after", {31'd0, in_ready}, 32'd1);
         chk("trit_valid_after", {31'd0, trit_valid}, 32'd0);
         chk("busy_after", {31'd0, busy}, 32'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      trit_ready = 1'b0;
      tick();
      tick();
      chk("rst_trit_valid", {31'd0, trit_valid}, 32'd0);
      chk("rst_trit", {30'd0, trit}, 32'd0);
      chk("rst_trit_last", {31'd0, trit_last}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("idle_trit_valid", {31'd0, trit_valid}, 32'd0);

      // Zero word: six 00 trits, last only on the sixth.
      send(8'd0);
      drain(N_TRITS, -1, 0, 1'b0, 0);

      // Largest word.
      send(8'd255);
      drain(N_TRITS, -1, 0, 1'b0, 255);

      // Back-pressure before the third trit.
      send(8'd200);
      drain(N_TRITS, 2, 3, 1'b0, 200);

      // in_valid held with another word during EMIT must not be captured.
      send(8'd5);
      in_valid = 1'b1;
      in_data  = 8'd7;
      drain(N_TRITS, -1, 0, 1'b0, 5);
      send(8'd7);
      drain(N_TRITS, -1, 0, 1'b0, 7);

      // Reset after the second trit discards the rest of the word.
      send(8'd255);
      drain(2, -1, 0, 1'b0, 0);
      rst = 1'b1;
      tick();
      chk("midrst_trit_valid", {31'd0, trit_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst_trit_last", {31'd0, trit_last}, 32'd0);
      chk("midrst_discarded", q.size(), N_TRITS - 2);
      q.delete();
      rst = 1'b0;
      tick();
      chk("postrst_trit_valid", {31'd0, trit_valid}, 32'd0);
      send(8'd1);
      drain(N_TRITS, -1, 0, 1'b0, 1);

      // Random words under random back-pressure.
      for (int k = 0; k < 20; k++) begin
         w = int'($urandom_range(0, 255));
         send(8'(w));
         drain(N_TRITS, -1, 0, 1'b1, w);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
